// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer slice.
//   game_state_e    : game_status codes driven to video/scroll/obstacle logic
//   player_status_e : outcome codes reported by the playfield logic
//   GS_W            : width of the game_status bus
package game_pkg;

  localparam int GS_W = 3;

  typedef enum logic [GS_W-1:0] {
    GS_START     = 3'd0,
    GS_PLAYING   = 3'd1,
    GS_LEVEL_UP  = 3'd2,
    GS_WORLD_UP  = 3'd3,
    GS_LIFE_LOST = 3'd4,
    GS_GAME_OVER = 3'd5,
    GS_WIN       = 3'd6
  } game_state_e;

  typedef enum logic [1:0] {
    PS_PLAYING  = 2'd0,
    PS_PASS     = 2'd1,
    PS_DIED     = 2'd2,
    PS_RESERVED = 2'd3  // behaves exactly like PS_PLAYING
  } player_status_e;

  // Transition screens that time out back into play.
  function automatic logic is_banner(game_state_e s);
    return (s == GS_LEVEL_UP) || (s == GS_WORLD_UP) || (s == GS_LIFE_LOST);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer and the playfield/video side.
//   start_btn     : raw start button (asynchronous)
//   frame_tick    : one-cycle pulse per video frame
//   player_status : outcome code from the playfield
//   game_status, world, level, lives, freeze, obj_reset : sequencer outputs
// master = playfield side (drives the inputs), slave = sequencer.
interface game_sequencer_if;
  import game_pkg::*;

  logic            start_btn;
  logic            frame_tick;
  logic [1:0]      player_status;
  logic [GS_W-1:0] game_status;
  logic [1:0]      world;
  logic [2:0]      level;
  logic [3:0]      lives;
  logic            freeze;
  logic            obj_reset;

  modport master (
    output start_btn, frame_tick, player_status,
    input  game_status, world, level, lives, freeze, obj_reset
  );

  modport slave (
    input  start_btn, frame_tick, player_status,
    output game_status, world, level, lives, freeze, obj_reset
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Button synchronizer and rising-edge detector.
//   clk, rst  : clock, asynchronous active-low reset
//   btn_in    : raw button, asynchronous to clk
//   btn_edge  : one-cycle pulse per press; a held button yields one pulse
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_edge
);

  logic sync1_q, sync2_q, sync3_q;

  // NOTE: non-blocking assignments make each flop sample the previous stage's
  // old value, so the chain really is three registers deep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign btn_edge = sync2_q & ~sync3_q;

endmodule

// File: rtl/game_sequencer.sv
// Top-level game controller: sequences levels, worlds and lives, holds timed
// transition screens and re-seeds playfield objects at each attempt.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : game_sequencer_if.slave (button, frame tick, player outcome in;
//              game_status/world/level/lives/freeze/obj_reset out, all registered)
module game_sequencer
  import game_pkg::*;
#(
  parameter int LEVELS_PER_WORLD = 4,
  parameter int NUM_WORLDS       = 4,
  parameter int START_LIVES      = 3,
  parameter int BANNER_FRAMES    = 120
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  bus
);

  localparam int          CNT_W       = $clog2(BANNER_FRAMES + 1);
  localparam logic [2:0]  LAST_LEVEL  = 3'(LEVELS_PER_WORLD - 1);
  localparam logic [1:0]  LAST_WORLD  = 2'(NUM_WORLDS - 1);
  localparam logic [3:0]  INIT_LIVES  = 4'(START_LIVES);
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_FRAMES - 1);

  logic start_edge;

  btn_sync_edge u_start_sync (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (bus.start_btn),
    .btn_edge (start_edge)
  );

  game_state_e      state_q, state_d;
  player_status_e   ps_q, ps_d;
  logic [1:0]       world_q, world_d;
  logic [2:0]       level_q, level_d;
  logic [3:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             entry_q, entry_d;   // first cycle inside a banner state
  logic             freeze_q, freeze_d;
  logic             obj_reset_q, obj_reset_d;

  assign ps_d = player_status_e'(bus.player_status);

  always_comb begin
    // NOTE: every _d gets a default first so no branch can infer a latch.
    state_d     = state_q;
    world_d     = world_q;
    level_d     = level_q;
    lives_d     = lives_q;
    cnt_d       = cnt_q;
    entry_d     = 1'b0;
    obj_reset_d = 1'b0;

    case (state_q)
      GS_START: begin
        world_d = 2'd0;
        level_d = 3'd0;
        lives_d = INIT_LIVES;
        if (start_edge) begin
          state_d     = GS_PLAYING;
          obj_reset_d = 1'b1;
        end
      end

      GS_PLAYING: begin
        case (ps_q)
          PS_PASS: begin
            if (level_q < LAST_LEVEL) begin
              state_d = GS_LEVEL_UP;
              level_d = level_q + 3'd1;
            end else if (world_q < LAST_WORLD) begin
              state_d = GS_WORLD_UP;
              level_d = 3'd0;
              world_d = world_q + 2'd1;
            end else begin
              state_d = GS_WIN;
            end
          end
          PS_DIED: begin
            if (lives_q > 4'd1) begin
              state_d = GS_LIFE_LOST;
              lives_d = lives_q - 4'd1;
            end else begin
              state_d = GS_GAME_OVER;
              lives_d = 4'd0;
            end
          end
          default: ;
        endcase
        // Arm the banner timer; a tick on the entry cycle is masked by entry_q.
        if (is_banner(state_d)) begin
          cnt_d   = '0;
          entry_d = 1'b1;
        end
      end

      GS_LEVEL_UP, GS_WORLD_UP, GS_LIFE_LOST: begin
        if (bus.frame_tick && !entry_q) begin
          if (cnt_q == BANNER_LAST) begin
            state_d     = GS_PLAYING;
            obj_reset_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      GS_GAME_OVER, GS_WIN: begin
        if (start_edge) state_d = GS_START;
      end

      default: state_d = GS_START;
    endcase

    freeze_d = (state_d != GS_PLAYING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= GS_START;
      ps_q        <= PS_PLAYING;
      world_q     <= 2'd0;
      level_q     <= 3'd0;
      lives_q     <= INIT_LIVES;
      cnt_q       <= '0;
      entry_q     <= 1'b0;
      freeze_q    <= 1'b1;
      obj_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps_q        <= ps_d;
      world_q     <= world_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      freeze_q    <= freeze_d;
      obj_reset_q <= obj_reset_d;
    end
  end

  assign bus.game_status = state_q;
  assign bus.world       = world_q;
  assign bus.level       = level_q;
  assign bus.lives       = lives_q;
  assign bus.freeze      = freeze_q;
  assign bus.obj_reset   = obj_reset_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes expected state
// transitions computed by a game-rules model; a negedge monitor pops and
// compares whenever game_status changes.
module tb_game_sequencer;

  localparam int LPW = 4, NW = 4, SL = 3, BF = 120;
  localparam int ST_START = 0, ST_PLAY = 1, ST_LVL = 2, ST_WLD = 3,
                 ST_LIFE = 4, ST_OVER = 5, ST_WIN = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if bus ();

  game_sequencer #(
    .LEVELS_PER_WORLD (LPW),
    .NUM_WORLDS       (NW),
    .START_LIVES      (SL),
    .BANNER_FRAMES    (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int st;
    int world;
    int level;
    int lives;
    int obj_reset;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   prev_st;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Game-rules model
  int m_st, m_world, m_level, m_lives;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int obj);
    exp_t e;
    e = '{m_st, m_world, m_level, m_lives, obj};
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    cur     = '{ST_START, 0, 0, SL, 0};
    prev_st = ST_START;
  end

  always @(negedge clk) begin
    if (!rst) begin
      cur     = '{ST_START, 0, 0, SL, 0};
      prev_st = ST_START;
    end else begin
      if (int'(bus.game_status) != prev_st) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transition", int'(bus.game_status), prev_st);
        end else begin
          cur = exp_q.pop_front();
          check("sb_status", int'(bus.game_status), cur.st);
          check("sb_world", int'(bus.world), cur.world);
          check("sb_level", int'(bus.level), cur.level);
          check("sb_lives", int'(bus.lives), cur.lives);
          check("sb_obj_reset", int'(bus.obj_reset), cur.obj_reset);
        end
        prev_st = int'(bus.game_status);
      end else begin
        check("obj_reset_idle", int'(bus.obj_reset), 0);
        if (cur.st != ST_START) begin
          check("hold_world", int'(bus.world), cur.world);
          check("hold_level", int'(bus.level), cur.level);
          check("hold_lives", int'(bus.lives), cur.lives);
        end
      end
      check("freeze", int'(bus.freeze), (cur.st != ST_PLAY) ? 1 : 0);
    end
  end

  // Waits for game_status == want; returns edges taken, or -1 on timeout.
  // Button and player_status are released after two cycles.
  task automatic wait_status(input int want, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 2) begin
        bus.player_status = 2'd0;
        bus.start_btn     = 1'b0;
      end
    end while (int'(bus.game_status) != want && cycles < 20);
    if (int'(bus.game_status) != want) cycles = -1;
  endtask

  task automatic press_start(input int want);
    int cyc;
    bus.start_btn = 1'b1;
    wait_status(want, cyc);
    check("start_latency", cyc, 3);
  endtask

  task automatic start_game();
    m_st = ST_PLAY; m_world = 0; m_level = 0; m_lives = SL;
    push(1);
    press_start(ST_PLAY);
  endtask

  task automatic restart_game();
    m_st = ST_START;
    push(0);
    press_start(ST_START);
    m_world = 0; m_level = 0; m_lives = SL;
    repeat (2) begin @(posedge clk); #1; end
    check("start_lives", int'(bus.lives), SL);
    check("start_level", int'(bus.level), 0);
    check("start_world", int'(bus.world), 0);
    start_game();
  endtask

  // Called on the entry cycle of a banner state.
  task automatic run_banner(input int banner_st, input int n_ticks,
                            input bit entry_tick, input bit noise);
    bus.frame_tick = entry_tick;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    for (int k = 1; k <= n_ticks; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (noise && k <= 3) begin
        bus.player_status = 2'd2;
        bus.start_btn     = (k % 2 == 1);
      end else if (noise && k == 4) begin
        bus.player_status = 2'd0;
        bus.start_btn     = 1'b0;
      end
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      if (k == BF - 1) check("banner_hold", int'(bus.game_status), banner_st);
      if (k == BF) begin
        check("banner_exit", int'(bus.game_status), ST_PLAY);
        check("banner_obj_reset", int'(bus.obj_reset), 1);
      end
    end
  endtask

  // One decision from PLAYING; returns in PLAYING.
  task automatic play(input bit pass, input bit noise);
    int cyc;
    int banner;
    if (noise) begin
      bus.start_btn = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      bus.start_btn = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("play_ignores_start", int'(bus.game_status), ST_PLAY);
    end
    if (pass) begin
      if (m_level < LPW - 1) begin
        m_st = ST_LVL; m_level++;
      end else if (m_world < NW - 1) begin
        m_st = ST_WLD; m_level = 0; m_world++;
      end else begin
        m_st = ST_WIN;
      end
    end else begin
      if (m_lives > 1) begin
        m_st = ST_LIFE; m_lives--;
      end else begin
        m_st = ST_OVER; m_lives = 0;
      end
    end
    push(0);
    bus.player_status = pass ? 2'd1 : 2'd2;
    wait_status(m_st, cyc);
    check("status_latency", cyc, 2);
    if (m_st == ST_LVL || m_st == ST_WLD || m_st == ST_LIFE) begin
      banner = m_st;
      m_st   = ST_PLAY;
      push(1);
      run_banner(banner, BF, 1'($urandom_range(0, 1)), noise);
    end else begin
      restart_game();
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.start_btn     = 1'b0;
    bus.frame_tick    = 1'b0;
    bus.player_status = 2'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", int'(bus.game_status), ST_START);
    check("rst_lives", int'(bus.lives), SL);
    check("rst_level", int'(bus.level), 0);
    check("rst_world", int'(bus.world), 0);
    check("rst_freeze", int'(bus.freeze), 1);
    check("rst_obj_reset", int'(bus.obj_reset), 0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Reset then start
    start_game();
    check("first_obj_reset", int'(bus.obj_reset), 1);
    check("first_freeze", int'(bus.freeze), 0);
    @(posedge clk); #1;
    check("obj_reset_one_cycle", int'(bus.obj_reset), 0);

    // Level/world advance all the way to WIN (first with ignored-input noise)
    for (int i = 0; i < LPW * NW; i++) play(1'b1, i < 2);

    // Death path down to GAME_OVER
    for (int i = 0; i < SL; i++) play(1'b0, 1'b0);

    // Asynchronous reset in the middle of a LIFE_LOST banner
    m_st = ST_LIFE; m_lives--;
    push(0);
    bus.player_status = 2'd2;
    wait_status(ST_LIFE, cyc);
    check("life_lost_latency", cyc, 2);
    run_banner(ST_LIFE, 50, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_status", int'(bus.game_status), ST_START);
    check("mid_rst_lives", int'(bus.lives), SL);
    check("mid_rst_freeze", int'(bus.freeze), 1);
    check("mid_rst_obj_reset", int'(bus.obj_reset), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("post_rst_status", int'(bus.game_status), ST_START);
    check("post_rst_obj_reset", int'(bus.obj_reset), 0);
    start_game();

    // Randomized play
    for (int i = 0; i < 30; i++)
      play($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 20);

    repeat (5) begin @(posedge clk); #1; end
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller that sequences play through levels, worlds and lives. It takes the player outcome reported by the playfield logic (scrolls, obstacles, player object), holds timed transition screens, and drives `game_status`, `world`, `level` and `lives` to the video, scroll and obstacle generators. It also drives a freeze flag and a one-cycle object-reset pulse that re-seed object positions at the start of each attempt.

## Interface
Parameters:
- `LEVELS_PER_WORLD`, 4: levels per world, range 1..8.
- `NUM_WORLDS`, 4: number of worlds, range 1..4.
- `START_LIVES`, 3: lives at game start, range 1..15.
- `BANNER_FRAMES`, 120: frames each transition screen is held, range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  raw start button, asynchronous to `clk`.
- `frame_tick`  in  1  one-cycle pulse per video frame, synchronous to `clk`.
- `player_status`  in  2  outcome code: 0 = playing, 1 = level passed, 2 = died, 3 = reserved and treated as 0.
- `game_status`  out  3  current state code (see Operation).
- `world`  out  2  current world index.
- `level`  out  3  current level index within the world.
- `lives`  out  4  remaining lives.
- `freeze`  out  1  high when playfield objects must hold still.
- `obj_reset`  out  1  one-cycle pulse; playfield objects return to their start positions.

## Operation
- State codes (`game_status`): 0 START, 1 PLAYING, 2 LEVEL_UP, 3 WORLD_UP, 4 LIFE_LOST, 5 GAME_OVER, 6 WIN. Code 7 is unused; if reached, the FSM goes to START.
- `freeze` = 1 in every state except PLAYING.
- START:
  - Holds `level` = 0, `world` = 0, `lives` = START_LIVES.
  - A start edge moves the FSM to PLAYING and pulses `obj_reset`.
- PLAYING, one decision per cycle on registered `player_status`:
  - 1 (level passed):
    - If `level` < LEVELS_PER_WORLD-1: go to LEVEL_UP and increment `level`.
    - Else, if `world` < NUM_WORLDS-1: go to WORLD_UP, set `level` = 0 and increment `world`.
    - Else: go to WIN.
  - 2 (died):
    - If `lives` > 1: go to LIFE_LOST and decrement `lives`.
    - Else: go to GAME_OVER and set `lives` = 0.
  - 0 or 3: stay in PLAYING.
  - Start edges are ignored.
- LEVEL_UP, WORLD_UP, LIFE_LOST:
  - A banner counter clears on entry and counts `frame_tick` pulses.
  - On the BANNER_FRAMES-th pulse after entry, go to PLAYING and pulse `obj_reset` on that same transition.
  - `player_status` and start edges are ignored in these states.
- GAME_OVER, WIN:
  - Counters hold.
  - A start edge goes to START, which reinitializes the counters on the following cycle.
- Start edge detection: `start_btn` passes through a two-flop synchronizer, then a third register. An edge is (sync2 & ~sync3).
- Counter updates happen only on the state-transition cycle. Counters never wrap: `level` saturates via the WORLD_UP/WIN branch and `lives` floors at 0.

## Timing
- Reset (`rst` low), asynchronous, takes effect immediately:
  - `game_status` = 0, `world` = 0, `level` = 0, `lives` = START_LIVES.
  - `freeze` = 1, `obj_reset` = 0.
  - Synchronizer flops = 0; banner counter = 0.
- Reset released mid-banner or mid-game always resumes in START with no `obj_reset`.
- All outputs are registered. `obj_reset` is high for exactly the one cycle in which `game_status` first reads 1.
- Start latency: `start_btn` rising before clk edge N gives `game_status` = 1 after edge N+2 (3 edges). A button held high produces only one edge.
- `player_status` is registered once. A value present before edge N gives the new state and counters after edge N+1. `player_status` must hold its value for at least 2 cycles.
- A `frame_tick` on the entry cycle of a banner state is not counted.
- Banner duration is BANNER_FRAMES ticks, independent of `clk` frequency.
- A start edge and `player_status` = 1 in the same cycle while in PLAYING: the status wins.

## Structure
- Shared package `game_pkg`:
  - State code constants `GS_START` … `GS_WIN`.
  - Player status codes `PS_PLAYING`, `PS_PASS`, `PS_DIED`.
  - `game_status` width constant.
- Sub-module `btn_sync_edge`: two-flop synchronizer plus edge register; outputs a one-cycle `edge` pulse. It is reused later for other buttons.
- Banner counter width: clog2(BANNER_FRAMES+1).

## Test plan
- Reset then start: after reset, `lives` = 3, `game_status` = 0, `freeze` = 1. Pulse `start_btn` → `game_status` = 1 after 3 edges, `obj_reset` high for 1 cycle, `freeze` = 0.
- Level advance: in PLAYING, `level` = 0, `player_status` = 1 for 2 cycles → `game_status` = 2 and `level` = 1. After 120 `frame_tick`s → `game_status` = 1 with an `obj_reset` pulse.
- World wrap: `level` = 3, `world` = 0, status 1 → `game_status` = 3, `level` = 0, `world` = 1. With `world` = 3, `level` = 3, status 1 → `game_status` = 6.
- Death path: `lives` = 3, status 2 → `game_status` = 4, `lives` = 2. Repeat until `lives` = 1, then status 2 → `game_status` = 5, `lives` = 0. Start → `game_status` = 0, then `lives` = 3.
- Ignored inputs: start pulses during PLAYING and `player_status` = 2 during LEVEL_UP → no state or counter change. A `frame_tick` on the entry cycle is not counted (exit on the 120th later tick).
- Async reset mid-banner: assert `rst` low at frame 50 of LIFE_LOST → outputs immediately at reset values. After release, the FSM stays in START until a start edge.
